// File: rtl/gmsk_pkg.sv
// Shared constants for the GMSK core register file and scoreboard.
package gmsk_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned NREG_DEFAULT = 32;
    localparam int unsigned REG_ZERO     = 0;

endpackage

// File: rtl/gmsk_sb_bits.sv
// Pending-write scoreboard: one busy bit per register plus a registered popcount.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   set_en/set_addr    mark a register pending (accepted allocation)
//   clr_en/clr_addr    clear a register's pending bit (writeback)
//   busy               current busy vector (register 0 always 0)
//   busy_cnt           number of set busy bits
module gmsk_sb_bits
    import gmsk_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEFAULT,
    parameter int unsigned AW   = $clog2(NREG),
    parameter int unsigned CW   = $clog2(NREG + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en,
    input  logic [AW-1:0]   set_addr,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_addr,
    output logic [NREG-1:0] busy,
    output logic [CW-1:0]   busy_cnt
);

    logic [NREG-1:0] busy_q, busy_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            set_ok, clr_ok, inc, dec;

    // Next busy vector and count delta; a set on the same address as a clear wins.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        set_ok = set_en && (set_addr != AW'(REG_ZERO));
        clr_ok = clr_en && (clr_addr != AW'(REG_ZERO));
        inc    = set_ok && !busy_q[set_addr];
        dec    = clr_ok && busy_q[clr_addr] && !(set_ok && (set_addr == clr_addr));
        if (clr_ok) busy_d[clr_addr] = 1'b0;
        if (set_ok) busy_d[set_addr] = 1'b1;
        if (inc && !dec)
            cnt_d = cnt_q + CW'(1);
        else if (dec && !inc)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = cnt_q;

endmodule

// File: rtl/gmsk_regfile_sb.sv
// Integer register file with NRD bypassed read ports and a pending-write scoreboard.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   rd_addr/rd_use               per-port read address and operand-needed flag
//   rd_data/rd_busy              combinational read data (wb bypass) and pending flag
//   stall                        any needed operand pending, or allocation refused
//   wb_en/wb_addr/wb_data        writeback
//   alloc_en/alloc_addr          destination claim from issue
//   alloc_stall                  claim refused on WAW hazard
//   dbg_addr/dbg_data            architectural read, no bypass
//   busy_cnt                     number of pending registers
module gmsk_regfile_sb
    import gmsk_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT,
    parameter int unsigned NREG = NREG_DEFAULT,
    parameter int unsigned NRD  = 2,
    parameter int unsigned AW   = $clog2(NREG)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NRD*AW-1:0]         rd_addr,
    input  logic [NRD-1:0]            rd_use,
    output logic [NRD*XLEN-1:0]       rd_data,
    output logic [NRD-1:0]            rd_busy,
    output logic                      stall,
    input  logic                      wb_en,
    input  logic [AW-1:0]             wb_addr,
    input  logic [XLEN-1:0]           wb_data,
    input  logic                      alloc_en,
    input  logic [AW-1:0]             alloc_addr,
    output logic                      alloc_stall,
    input  logic [AW-1:0]             dbg_addr,
    output logic [XLEN-1:0]           dbg_data,
    output logic [$clog2(NREG+1)-1:0] busy_cnt
);

    localparam int unsigned CW = $clog2(NREG + 1);

    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] mem_d [NREG];
    logic [NREG-1:0] busy;
    logic            wb_ok;
    logic            alloc_ok;

    assign wb_ok = wb_en && (wb_addr != AW'(REG_ZERO));

    // Storage update; writes to register 0 are dropped.
    always_comb begin
        for (int i = 0; i < int'(NREG); i++) mem_d[i] = mem_q[i];
        if (wb_ok) mem_d[wb_addr] = wb_data;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NREG); i++) begin
            if (rst) mem_q[i] <= '0;
            else     mem_q[i] <= mem_d[i];
        end
    end

    // A same-cycle writeback to the claimed register retires the old producer, so no WAW.
    assign alloc_stall = alloc_en && (alloc_addr != AW'(REG_ZERO)) && busy[alloc_addr]
                         && !(wb_en && (wb_addr == alloc_addr));
    assign alloc_ok    = alloc_en && (alloc_addr != AW'(REG_ZERO)) && !alloc_stall;

    gmsk_sb_bits #(
        .NREG (NREG),
        .AW   (AW),
        .CW   (CW)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (alloc_ok),
        .set_addr (alloc_addr),
        .clr_en   (wb_ok),
        .clr_addr (wb_addr),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    // Read ports with same-cycle writeback bypass.
    for (genvar i = 0; i < int'(NRD); i++) begin : g_rd
        logic [AW-1:0] addr;
        logic          hit;
        assign addr = rd_addr[i*AW +: AW];
        assign hit  = wb_en && (wb_addr == addr);
        assign rd_data[i*XLEN +: XLEN] = (addr == AW'(REG_ZERO)) ? '0
                                       : (hit ? wb_data : mem_q[addr]);
        assign rd_busy[i] = busy[addr] && !hit;
    end

    assign stall    = (|(rd_use & rd_busy)) || alloc_stall;
    assign dbg_data = mem_q[dbg_addr];

endmodule

// File: tb/tb_gmsk_regfile_sb.sv
module tb_gmsk_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;
    localparam int CW   = 6;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD-1:0]       rd_use;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_busy;
    logic                 stall;
    logic                 wb_en;
    logic [AW-1:0]        wb_addr;
    logic [XLEN-1:0]      wb_data;
    logic                 alloc_en;
    logic [AW-1:0]        alloc_addr;
    logic                 alloc_stall;
    logic [AW-1:0]        dbg_addr;
    logic [XLEN-1:0]      dbg_data;
    logic [CW-1:0]        busy_cnt;

    gmsk_regfile_sb dut (
        .clk         (clk),
        .rst         (rst),
        .rd_addr     (rd_addr),
        .rd_use      (rd_use),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .stall       (stall),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .alloc_en    (alloc_en),
        .alloc_addr  (alloc_addr),
        .alloc_stall (alloc_stall),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .busy_cnt    (busy_cnt)
    );

    always #5 clk = ~clk;

    typedef enum int {S_RD0, S_RD1, S_BUSY, S_STALL, S_ASTALL, S_DBG, S_CNT} sel_e;
    typedef struct {
        sel_e        sel;
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    logic [XLEN-1:0] m_mem [NREG];
    logic [NREG-1:0] m_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] observe(input sel_e s);
        case (s)
            S_RD0:    return rd_data[31:0];
            S_RD1:    return rd_data[63:32];
            S_BUSY:   return 32'(rd_busy);
            S_STALL:  return 32'(stall);
            S_ASTALL: return 32'(alloc_stall);
            S_DBG:    return dbg_data;
            default:  return 32'(busy_cnt);
        endcase
    endfunction

    task automatic push(input sel_e s, input string tag, input logic [31:0] exp);
        exp_t e;
        e.sel = s; e.tag = tag; e.exp = exp;
        sb_q.push_back(e);
    endtask

    // Settle, then pop every pending expectation and compare against the DUT.
    task automatic drain();
        exp_t e;
        #2;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; rd_addr = '0; rd_use = '0; wb_en = 1'b0; wb_addr = '0;
        wb_data = '0; alloc_en = 1'b0; alloc_addr = '0; dbg_addr = '0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr = {AW'(a1), AW'(a0)};
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NREG; i++) m_mem[i] = '0;
        m_busy = '0;
    endtask

    // One random cycle: expectations from the bench model, then model update at the edge.
    task automatic rand_cycle();
        logic [AW-1:0] a [2];
        logic [1:0]    eb;
        logic          hit, ast;
        logic [31:0]   ed;
        rd_use     = 2'($urandom_range(0, 3));
        a[0]       = AW'($urandom_range(0, 7));
        a[1]       = AW'($urandom_range(0, 7));
        set_rd(int'(a[0]), int'(a[1]));
        wb_en      = 1'($urandom_range(0, 1));
        wb_addr    = AW'($urandom_range(0, 7));
        wb_data    = $urandom;
        alloc_en   = 1'($urandom_range(0, 1));
        alloc_addr = AW'($urandom_range(0, 7));
        dbg_addr   = AW'($urandom_range(0, 7));
        for (int p = 0; p < 2; p++) begin
            hit   = wb_en && (wb_addr == a[p]);
            ed    = (a[p] == 0) ? 32'h0 : (hit ? wb_data : m_mem[a[p]]);
            eb[p] = (a[p] != 0) && m_busy[a[p]] && !hit;
            push((p == 0) ? S_RD0 : S_RD1, (p == 0) ? "rnd_rd0" : "rnd_rd1", ed);
        end
        ast = alloc_en && (alloc_addr != 0) && m_busy[alloc_addr] && !(wb_en && wb_addr == alloc_addr);
        push(S_BUSY, "rnd_busy", 32'(eb));
        push(S_ASTALL, "rnd_astall", 32'(ast));
        push(S_STALL, "rnd_stall", 32'((|(rd_use & eb)) || ast));
        push(S_DBG, "rnd_dbg", m_mem[dbg_addr]);
        push(S_CNT, "rnd_cnt", 32'($countones(m_busy)));
        drain();
        if (wb_en && wb_addr != 0) begin
            m_mem[wb_addr]  = wb_data;
            m_busy[wb_addr] = 1'b0;
        end
        if (alloc_en && alloc_addr != 0 && !ast) m_busy[alloc_addr] = 1'b1;
        tick();
    endtask

    initial begin
        idle();
        #1;
        // 1: reset state on every address
        do_reset();
        rd_use = 2'b11;
        for (int i = 0; i < NREG; i++) begin
            set_rd(i, i);
            dbg_addr = AW'(i);
            push(S_RD0, "rst_rd0", 0);
            push(S_RD1, "rst_rd1", 0);
            push(S_DBG, "rst_dbg", 0);
            push(S_BUSY, "rst_busy", 0);
            push(S_STALL, "rst_stall", 0);
            push(S_CNT, "rst_cnt", 0);
            drain();
        end
        idle();

        // 2: bypass then architectural visibility
        wb_en = 1'b1; wb_addr = 5; wb_data = 32'h1234; set_rd(5, 0); dbg_addr = 5;
        push(S_RD0, "byp_rd0", 32'h1234);
        push(S_DBG, "byp_dbg_old", 0);
        drain();
        tick();
        wb_en = 1'b0;
        push(S_DBG, "dbg_after_wb", 32'h1234);
        push(S_RD0, "rd0_stored", 32'h1234);
        drain();

        // 3: register 0 is hardwired
        wb_en = 1'b1; wb_addr = 0; wb_data = 32'hFFFF_FFFF; set_rd(0, 0); rd_use = 2'b11;
        push(S_RD0, "r0_rd0", 0);
        push(S_BUSY, "r0_busy", 0);
        drain();
        tick();
        wb_en = 1'b0; alloc_en = 1'b1; alloc_addr = 0; dbg_addr = 0;
        push(S_ASTALL, "r0_astall", 0);
        push(S_DBG, "r0_dbg", 0);
        drain();
        tick();
        alloc_en = 1'b0;
        push(S_CNT, "r0_cnt", 0);
        drain();
        idle();

        // 4: RAW hazard resolved by writeback
        alloc_en = 1'b1; alloc_addr = 3;
        push(S_ASTALL, "a3_astall", 0);
        drain();
        tick();
        alloc_en = 1'b0; set_rd(0, 3); rd_use = 2'b10;
        push(S_BUSY, "raw_busy", 32'b10);
        push(S_STALL, "raw_stall", 1);
        push(S_CNT, "raw_cnt", 1);
        drain();
        wb_en = 1'b1; wb_addr = 3; wb_data = 7;
        push(S_BUSY, "raw_wb_busy", 0);
        push(S_RD1, "raw_wb_rd1", 7);
        push(S_STALL, "raw_wb_stall", 0);
        drain();
        tick();
        wb_en = 1'b0;
        push(S_CNT, "raw_cnt_after", 0);
        push(S_RD1, "raw_rd1_stored", 7);
        drain();
        idle();

        // 5: WAW refused, then accepted alongside writeback to the same register
        alloc_en = 1'b1; alloc_addr = 4;
        tick();
        push(S_ASTALL, "waw_astall", 1);
        push(S_STALL, "waw_stall", 1);
        drain();
        tick();
        push(S_CNT, "waw_cnt", 1);
        wb_en = 1'b1; wb_addr = 4; wb_data = 32'hABCD;
        push(S_ASTALL, "waw_wb_astall", 0);
        drain();
        tick();
        alloc_en = 1'b0; wb_en = 1'b0; set_rd(4, 0);
        push(S_CNT, "waw_wb_cnt", 1);
        push(S_BUSY, "waw_wb_busy", 32'b01);
        push(S_RD0, "waw_wb_rd0", 32'hABCD);
        drain();
        wb_en = 1'b1; wb_addr = 4; wb_data = 1;
        tick();
        wb_en = 1'b0;
        push(S_CNT, "waw_clean_cnt", 0);
        drain();
        idle();

        // 6: reset discards pending allocations and same-cycle writeback
        for (int r = 6; r <= 8; r++) begin
            alloc_en = 1'b1; alloc_addr = AW'(r);
            tick();
        end
        alloc_en = 1'b0;
        push(S_CNT, "pre_rst_cnt", 3);
        drain();
        rst = 1'b1; wb_en = 1'b1; wb_addr = 6; wb_data = 32'h55; alloc_en = 1'b1; alloc_addr = 9;
        tick();
        idle();
        set_rd(6, 7); dbg_addr = 6; rd_use = 2'b11;
        push(S_CNT, "mid_rst_cnt", 0);
        push(S_DBG, "mid_rst_dbg6", 0);
        push(S_BUSY, "mid_rst_busy", 0);
        push(S_RD0, "mid_rst_rd0", 0);
        push(S_STALL, "mid_rst_stall", 0);
        drain();
        set_rd(8, 9);
        push(S_BUSY, "mid_rst_busy89", 0);
        drain();

        // Random traffic against the bench model
        do_reset();
        for (int n = 0; n < 400; n++) rand_cycle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule

// File: doc/gmsk_regfile_sb.md
Name: gmsk_regfile_sb

Overview:
Parametrised successor to the P1 core's integer register file. Adds N configurable read ports, same-cycle write-to-read bypass, and a per-register pending-write scoreboard with hazard/stall outputs. Sits between decode/issue and writeback in the next-generation pipelined GMSK core. Also provides a side-band debug read port for bench checks.

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of architectural registers; register 0 is hardwired to zero
NRD, 2, number of read ports
AW, $clog2(NREG), register address width (derived; do not override)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
rd_addr  in  NRD*AW  read addresses, port i at bits [i*AW +: AW]
rd_use  in  NRD  port i operand is actually needed this cycle
rd_data  out  NRD*XLEN  read data, port i at bits [i*XLEN +: XLEN]
rd_busy  out  NRD  port i source has a pending write not satisfied this cycle
stall  out  1  OR over i of (rd_use[i] & rd_busy[i]), OR alloc_stall
wb_en  in  1  writeback valid
wb_addr  in  AW  writeback destination
wb_data  in  XLEN  writeback value
alloc_en  in  1  issue claims a destination register
alloc_addr  in  AW  claimed destination
alloc_stall  out  1  allocation refused because of a WAW hazard
dbg_addr  in  AW  debug read address
dbg_data  out  XLEN  debug read data, architectural value, no bypass
busy_cnt  out  $clog2(NREG+1)  count of pending registers (registered)

Behaviour:
- Reset (sync, rst=1 at posedge): all registers cleared to 0, all busy bits cleared, busy_cnt=0. Reset applied mid-operation discards pending allocations; the same-cycle wb/alloc are ignored.
- Reads are combinational (0 latency).
  - addr 0 always returns 0.
  - If wb_en and wb_addr==rd_addr!=0, return wb_data (bypass); otherwise return the stored register value.
- Write: at posedge, if wb_en and wb_addr!=0, the register is updated. Writes to 0 are dropped and never set busy.
- rd_busy[i] = busy[rd_addr[i]] & !(wb_en & wb_addr==rd_addr[i]). Always 0 for address 0.
- Scoreboard per-register next state, at posedge:
  - wb clears busy[wb_addr].
  - An accepted alloc sets busy[alloc_addr].
  - Same address on both in one cycle: set wins (new producer pending).
- alloc_stall = alloc_en & alloc_addr!=0 & busy[alloc_addr] & !(wb_en & wb_addr==alloc_addr).
  - When alloc_stall=1 the allocation is not recorded.
  - Allocation to address 0 is accepted and is a no-op.
- stall is combinational. Issue logic must hold its instruction while stall=1.
- busy_cnt tracks the popcount of busy bits. It updates by +1, −1 or 0 per cycle, including the simultaneous alloc+wb case on different addresses (net 0). It is registered, so it always equals the popcount of the current busy vector.
- wb to a non-busy register is legal: data is written and busy is unchanged.
- dbg_data reflects the stored value only. A write becomes visible on dbg_data the cycle after it is accepted.

Decomposition:
- Shared package gmsk_pkg holds XLEN_DEFAULT, NREG_DEFAULT, and the REG_ZERO=0 constant.
- One sub-module, gmsk_sb_bits: busy-bit vector plus busy_cnt, with inputs set/clr address+enable and outputs busy vector and count.
- The storage array and bypass mux stay in the top module.

Test Plan:
1. Reset, then read all 32 addresses on both ports and dbg -> all 0; busy_cnt=0; stall=0.
2. wb_en=1, wb_addr=5, wb_data=0x1234 with rd_addr0=5 in the same cycle -> rd_data0=0x1234 that cycle; dbg_data(5)=0x1234 the next cycle.
3. Write 0xFFFF_FFFF to register 0 -> rd_data(0)=0 and rd_busy=0. Also alloc 0 -> alloc_stall=0 and busy_cnt stays 0.
4. alloc 3; next cycle rd_addr1=3, rd_use1=1 -> rd_busy1=1, stall=1, busy_cnt=1. Then wb 3=7 -> rd_busy1=0, rd_data1=7, stall=0 that cycle; busy_cnt=0 next cycle.
5. alloc 4, then alloc 4 again -> second gives alloc_stall=1. Same cycle as wb 4 -> alloc_stall=0, busy stays 1, busy_cnt=1.
6. alloc 6/7/8 in successive cycles, then rst=1 together with wb 6 -> the next cycle shows busy_cnt=0, register 6 = 0, and all rd_busy=0.
